// File: rtl/bumper_backtrack_timer_pkg.sv
// Shared types and helpers for the bumper backtrack timer.
package bumper_timer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        RUN      = 2'd2,
        WAIT_REL = 2'd3
    } bt_state_t;

    localparam int unsigned TRIG_ALL = 0;
    localparam int unsigned TRIG_ANY = 1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bumper_backtrack_timer_if.sv
// Bumper inputs and display/steering outputs of the backtrack timer.
interface bumper_backtrack_timer_if #(
    parameter int unsigned N_BUMPERS  = 2,
    parameter int unsigned DURATION_S = 5
);
    localparam int unsigned SECS_W = $clog2(DURATION_S + 1);

    logic [N_BUMPERS-1:0] bumper;
    logic                 abort;
    logic                 active;
    logic                 done_pulse;
    logic [SECS_W-1:0]    secs_left;
    logic [N_BUMPERS-1:0] trig_cause;

    modport master (
        output bumper, abort,
        input  active, done_pulse, secs_left, trig_cause
    );

    modport slave (
        input  bumper, abort,
        output active, done_pulse, secs_left, trig_cause
    );

endinterface

// File: rtl/bumper_backtrack_timer_sec_tick_gen.sv
// Free-running sub-second counter; pulses once per CLK_HZ enabled cycles.
module sec_tick_gen
    import bumper_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic sec_tick
);

    localparam int unsigned   TW       = cnt_width(CLK_HZ);
    localparam logic [TW-1:0] TICK_MAX = TW'(CLK_HZ - 1);

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;

    // Next tick: clear wins over counting; wraps at CLK_HZ-1.
    always_comb begin
        tick_d = tick_q;
        if (clr) begin
            tick_d = '0;
        end else if (en) begin
            tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
        end
    end

    // Tick register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign sec_tick = en & (tick_q == TICK_MAX);

endmodule

// File: rtl/bumper_backtrack_timer.sv
// Backtrack timer: qualifies a bumper trigger, runs for DURATION_S seconds,
// then waits for bumper release before re-arming.
module bumper_backtrack_timer
    import bumper_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned DURATION_S  = 5,
    parameter int unsigned N_BUMPERS   = 2,
    parameter int unsigned TRIG_MODE   = 0,
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned RETRIGGER   = 0
) (
    input logic                      clk,
    input logic                      rst,
    bumper_backtrack_timer_if.slave  bus
);

    localparam int unsigned         SECS_W    = $clog2(DURATION_S + 1);
    localparam int unsigned         HW        = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SECS_W-1:0]   SECS_INIT = SECS_W'(DURATION_S);

    bt_state_t            state_q, state_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [SECS_W-1:0]    secs_q, secs_d;
    logic [N_BUMPERS-1:0] cause_q, cause_d;
    logic                 done_q, done_d;
    logic                 cond, cond_q, rise;
    logic                 retrig;
    logic                 sec_tick;

    assign cond = (TRIG_MODE == TRIG_ANY) ? |bus.bumper : &bus.bumper;
    assign rise = cond & ~cond_q;

    // Tick counter is held at zero outside RUN, so RUN entry always starts a fresh second.
    sec_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      ((state_q != RUN) | retrig),
        .en       (state_q == RUN),
        .sec_tick (sec_tick)
    );

    // FSM next state: abort > expiry > retrigger > hold qualification.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        secs_d  = secs_q;
        cause_d = cause_q;
        done_d  = 1'b0;
        retrig  = 1'b0;
        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (cond) begin
                    if (HOLD_CYCLES == 1) begin
                        state_d = RUN;
                        secs_d  = SECS_INIT;
                        cause_d = bus.bumper;
                    end else begin
                        state_d = ARM;
                        hold_d  = HW'(1);
                    end
                end
            end
            ARM: begin
                if (bus.abort) begin
                    state_d = WAIT_REL;
                    hold_d  = '0;
                end else if (!cond) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                    hold_d  = '0;
                    secs_d  = SECS_INIT;
                    cause_d = bus.bumper;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = WAIT_REL;
                    secs_d  = '0;
                end else if (sec_tick && secs_q == SECS_W'(1)) begin
                    state_d = WAIT_REL;
                    secs_d  = '0;
                    done_d  = 1'b1;
                end else if (RETRIGGER != 0 && rise) begin
                    retrig  = 1'b1;
                    secs_d  = SECS_INIT;
                    cause_d = bus.bumper;
                end else if (sec_tick) begin
                    secs_d = secs_q - 1'b1;
                end
            end
            WAIT_REL: begin
                // Held bumpers must be released before a new trigger is accepted.
                if (!cond) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            secs_q  <= '0;
            cause_q <= '0;
            done_q  <= 1'b0;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            secs_q  <= secs_d;
            cause_q <= cause_d;
            done_q  <= done_d;
            cond_q  <= cond;
        end
    end

    assign bus.active     = (state_q == RUN);
    assign bus.done_pulse = done_q;
    assign bus.secs_left  = secs_q;
    assign bus.trig_cause = cause_q;

endmodule

// File: tb/tb_bumper_backtrack_timer.sv
// Directed bench: ALL, ANY and retrigger instances sharing clk/rst.
module tb_bumper_backtrack_timer;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   hits;

    always #5 clk = ~clk;

    bumper_backtrack_timer_if #(.N_BUMPERS(2), .DURATION_S(3)) if_all ();
    bumper_backtrack_timer_if #(.N_BUMPERS(2), .DURATION_S(3)) if_any ();
    bumper_backtrack_timer_if #(.N_BUMPERS(2), .DURATION_S(3)) if_ret ();

    bumper_backtrack_timer #(
        .CLK_HZ(10), .DURATION_S(3), .N_BUMPERS(2), .TRIG_MODE(0), .HOLD_CYCLES(4), .RETRIGGER(0)
    ) u_all (
        .clk (clk),
        .rst (rst),
        .bus (if_all)
    );

    bumper_backtrack_timer #(
        .CLK_HZ(10), .DURATION_S(3), .N_BUMPERS(2), .TRIG_MODE(1), .HOLD_CYCLES(4), .RETRIGGER(0)
    ) u_any (
        .clk (clk),
        .rst (rst),
        .bus (if_any)
    );

    bumper_backtrack_timer #(
        .CLK_HZ(10), .DURATION_S(3), .N_BUMPERS(2), .TRIG_MODE(0), .HOLD_CYCLES(4), .RETRIGGER(1)
    ) u_ret (
        .clk (clk),
        .rst (rst),
        .bus (if_ret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle just past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        if_all.bumper = 2'b00; if_all.abort = 1'b0;
        if_any.bumper = 2'b00; if_any.abort = 1'b0;
        if_ret.bumper = 2'b00; if_ret.abort = 1'b0;
        rst = 1'b1;
        step(2);
        check("rst active", if_all.active, 0);
        check("rst secs", if_all.secs_left, 0);
        check("rst cause", if_all.trig_cause, 0);
        check("rst done", if_all.done_pulse, 0);
        rst = 1'b0;

        // ALL mode basic run
        if_all.bumper = 2'b11;
        step(3);
        check("all hold3", if_all.active, 0);
        step(1);
        check("all start", if_all.active, 1);
        check("all secs c1", if_all.secs_left, 3);
        check("all cause", if_all.trig_cause, 3);
        step(9);
        check("all secs c10", if_all.secs_left, 3);
        step(1);
        check("all secs c11", if_all.secs_left, 2);
        step(10);
        check("all secs c21", if_all.secs_left, 1);
        step(9);
        check("all active c30", if_all.active, 1);
        check("all done c30", if_all.done_pulse, 0);
        step(1);
        check("all expired", if_all.active, 0);
        check("all done pulse", if_all.done_pulse, 1);
        check("all secs zero", if_all.secs_left, 0);
        step(1);
        check("all done once", if_all.done_pulse, 0);
        step(3);
        check("all wait_rel", if_all.active, 0);

        // Hold not met, then a full qualification from scratch
        if_all.bumper = 2'b00;
        step(1);
        if_all.bumper = 2'b11;
        step(3);
        check("short hold", if_all.active, 0);
        if_all.bumper = 2'b01;
        step(1);
        check("hold broken", if_all.active, 0);
        if_all.bumper = 2'b11;
        step(3);
        check("requal hold3", if_all.active, 0);
        step(1);
        check("requal start", if_all.active, 1);

        // Abort at cycle 12
        step(11);
        check("abort pre", if_all.active, 1);
        if_all.abort = 1'b1;
        step(1);
        if_all.abort = 1'b0;
        check("abort active", if_all.active, 0);
        check("abort secs", if_all.secs_left, 0);
        check("abort done", if_all.done_pulse, 0);
        hits = 0;
        for (int i = 0; i < 35; i++) begin
            step(1);
            hits += int'(if_all.done_pulse) + int'(if_all.active);
        end
        check("abort no done", hits, 0);

        // Reset mid-RUN at cycle 20
        if_all.bumper = 2'b00;
        step(1);
        if_all.bumper = 2'b11;
        step(4);
        check("rstrun start", if_all.active, 1);
        step(19);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst active", if_all.active, 0);
        check("midrst secs", if_all.secs_left, 0);
        check("midrst cause", if_all.trig_cause, 0);
        check("midrst done", if_all.done_pulse, 0);
        step(3);
        check("midrst hold3", if_all.active, 0);
        step(1);
        check("midrst restart", if_all.active, 1);
        check("midrst secs3", if_all.secs_left, 3);
        if_all.bumper = 2'b00;

        // ANY mode with release rule
        if_any.bumper = 2'b10;
        step(3);
        check("any hold3", if_any.active, 0);
        step(1);
        check("any start", if_any.active, 1);
        check("any cause", if_any.trig_cause, 2);
        step(29);
        check("any c30", if_any.active, 1);
        check("any secs c30", if_any.secs_left, 1);
        step(1);
        check("any expired", if_any.active, 0);
        check("any done", if_any.done_pulse, 1);
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            hits += int'(if_any.active);
        end
        check("any no rerun", hits, 0);
        if_any.bumper = 2'b00;
        step(1);
        if_any.bumper = 2'b01;
        step(3);
        check("any2 hold3", if_any.active, 0);
        step(1);
        check("any2 start", if_any.active, 1);
        check("any2 cause", if_any.trig_cause, 1);
        if_any.bumper = 2'b00;

        // Retrigger at cycle 15
        if_ret.bumper = 2'b11;
        step(4);
        check("ret start", if_ret.active, 1);
        step(13);
        if_ret.bumper = 2'b01;
        step(1);
        check("ret secs c15", if_ret.secs_left, 2);
        if_ret.bumper = 2'b11;
        step(1);
        check("ret reload", if_ret.secs_left, 3);
        check("ret active", if_ret.active, 1);
        step(5);
        check("ret secs c21", if_ret.secs_left, 3);
        step(24);
        check("ret c45", if_ret.active, 1);
        check("ret secs c45", if_ret.secs_left, 1);
        step(1);
        check("ret expired", if_ret.active, 0);
        check("ret done", if_ret.done_pulse, 1);

        // Rising edge on the expiry cycle: expiry wins
        if_ret.bumper = 2'b00;
        step(1);
        if_ret.bumper = 2'b11;
        step(4);
        check("exw start", if_ret.active, 1);
        step(28);
        if_ret.bumper = 2'b01;
        step(1);
        check("exw c30", if_ret.active, 1);
        if_ret.bumper = 2'b11;
        step(1);
        check("exw active", if_ret.active, 0);
        check("exw done", if_ret.done_pulse, 1);
        check("exw secs", if_ret.secs_left, 0);
        step(1);
        check("exw stay", if_ret.active, 0);
        check("exw done once", if_ret.done_pulse, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bumper_backtrack_timer.md
# bumper_backtrack_timer

Parametrised backtrack timer for the servo steering path. It watches N bumper inputs and qualifies a trigger condition (all-pressed or any-pressed) over a hold window. On a valid trigger it asserts `active` for exactly `DURATION_S` seconds, then waits for the bumpers to be released before it can re-arm. It sits between the bumper input synchronisers and the steering FSM, and also exports a seconds-remaining count and a trigger-cause snapshot for the display.

## Interface
- `CLK_HZ`, default 100_000_000: clk frequency; one second = `CLK_HZ` cycles (must be ≥ 1).
- `DURATION_S`, default 5: active duration in seconds (must be ≥ 1).
- `N_BUMPERS`, default 2: number of bumper inputs (must be ≥ 1).
- `TRIG_MODE`, default 0: 0 = ALL (trigger when `&bumper`), 1 = ANY (trigger when `|bumper`).
- `HOLD_CYCLES`, default 1: consecutive cycles the trigger condition must hold (must be ≥ 1).
- `RETRIGGER`, default 0: 1 = a rising edge of the condition during RUN restarts the full duration.

Ports (reset is `rst`, synchronous, active-high; clock is `clk`):
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous active-high reset.
- `bumper`, in, `N_BUMPERS`: already-synchronised bumper levels, 1 = pressed.
- `abort`, in, 1: cancels ARM or RUN.
- `active`, out, 1: backtrack in progress.
- `done_pulse`, out, 1: one-cycle pulse on normal expiry.
- `secs_left`, out, `$clog2(DURATION_S+1)`: whole seconds remaining; 0 outside RUN.
- `trig_cause`, out, `N_BUMPERS`: `bumper` value captured on RUN entry.

## Operation
- `cond = TRIG_MODE ? |bumper : &bumper`. `cond_q` is `cond` registered once.
- Priority: `rst` > `abort` > expiry > retrigger > hold qualification.
- **IDLE**
  - `hold_cnt` = 0.
  - If `cond` and `HOLD_CYCLES` = 1: go to RUN.
  - Else if `cond`: go to ARM with `hold_cnt` = 1.
- **ARM**
  - If `cond` = 0: go to IDLE.
  - If `cond` and `hold_cnt` = `HOLD_CYCLES`−1: go to RUN.
  - Otherwise increment `hold_cnt`.
  - `abort`: go to WAIT_REL.
- **RUN entry:** `tick` = 0, `secs_left` = `DURATION_S`, `trig_cause` = `bumper` (the value sampled on the entry edge).
- **RUN**
  - `tick` counts 0..`CLK_HZ`−1, then wraps. On wrap, `secs_left` decrements.
  - Expiry is `tick` = `CLK_HZ`−1 with `secs_left` = 1. On expiry: `secs_left` goes to 0, `done_pulse` = 1 for one cycle, go to WAIT_REL.
  - `abort`: go to WAIT_REL, `secs_left` = 0, no `done_pulse`.
  - If `RETRIGGER` = 1 and `cond & ~cond_q`: `tick` = 0, `secs_left` = `DURATION_S`, `trig_cause` recaptured. Ignored on the expiry cycle (expiry wins).
- **WAIT_REL:** stay until `cond` = 0, then go to IDLE. This blocks the immediate re-trigger that a held bumper would otherwise cause.
- `active` = (state == RUN).
- `abort` in IDLE or WAIT_REL: no effect.
- `trig_cause` holds its value until the next RUN entry or `rst`.

## Timing
- Reset values: state IDLE, `active` 0, `done_pulse` 0, `secs_left` 0, `trig_cause` 0, all counters 0, `cond_q` 0.
- **Trigger latency:** `active` rises on the edge that samples the `HOLD_CYCLES`-th consecutive `cond` = 1. With `HOLD_CYCLES` = 1, `active` is high the cycle after `cond` is first seen.
- **Duration:** `active` is high for exactly `DURATION_S`·`CLK_HZ` cycles when not retriggered or aborted.
- **Expiry:** `done_pulse` is high in the first cycle that `active` is low after expiry.
- **Abort:** `abort` sampled high in RUN drops `active` on the next cycle.
- **`secs_left` values:**
  - Equals `DURATION_S` during the first second, decrements at each wrap.
  - Never shows 0 while `active` is 1; shows 0 after expiry.
- **Widths:** `tick` width is `max(1,$clog2(CLK_HZ))`; `hold_cnt` width is `max(1,$clog2(HOLD_CYCLES))`. No counter may overflow or wrap outside the rules above.
- **Reset mid-RUN:** all outputs return to their reset values the next cycle, with no `done_pulse`.

## Structure
- Package `bumper_timer_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ARM, RUN, WAIT_REL} bt_state_t`;
  - `TRIG_ALL` = 0, `TRIG_ANY` = 1.
- Sub-module `sec_tick_gen` (parameter `CLK_HZ`):
  - inputs `clk`, `rst`, `clr`, `en`;
  - output `sec_tick`, a one-cycle pulse when `tick` = `CLK_HZ`−1;
  - `clr` forces `tick` to 0.
- The top level holds the FSM, hold counter, `secs_left` and edge detection.

## Test plan
Parameters unless stated: `CLK_HZ`=10, `DURATION_S`=3, `HOLD_CYCLES`=4, `N_BUMPERS`=2.
- **ALL mode, basic run:** `bumper`=11 held → `active` rises on the 4th sampled edge and stays high 30 cycles. `secs_left` reads 3,2,1 for 10 cycles each, then 0 with `done_pulse` for 1 cycle.
- **Hold not met:** `bumper`=11 for 3 cycles, then 01 → `active` stays 0 and state returns to IDLE.
- **ANY mode plus release rule:** `bumper`=10 held through expiry → no second run. Release, then 01 for 4 cycles → new run with `trig_cause`=01.
- **Retrigger and simultaneous events (`RETRIGGER`=1):** `cond` rising edge at cycle 15 of RUN → `active` lasts 15+30 cycles in total. A rising edge on the expiry cycle → expiry wins.
- **Abort:** `abort` at cycle 12 of RUN → `active` 0 the next cycle, `done_pulse` never asserts, `secs_left` 0.
- **Reset mid-RUN:** `rst` at cycle 20 → all outputs at reset values the next cycle. The run restarts only after `HOLD_CYCLES` qualification.
